// File: rtl/dual_issue_stage_pkg.sv
// Shared types for the SPU dual-issue decode stage.
package dual_issue_stage_pkg;

  typedef enum logic [3:0] {
    nop, lnop, a, ai, il, ila, fma,
    lqd, stqd, br, shlqbyi
  } opcode_t;

  typedef enum logic { EVEN, ODD } pipe_t;
  typedef enum logic { EMPTY, SECOND } state_t;

  localparam int RRR_W  = 4;
  localparam int RI18_W = 7;
  localparam int RI10_W = 8;
  localparam int RI16_W = 9;
  localparam int RR_W   = 11;

  localparam logic [RRR_W-1:0]  OPC_FMA  = 4'b1110;
  localparam logic [RI18_W-1:0] OPC_ILA  = 7'b0100001;
  localparam logic [RI10_W-1:0] OPC_AI   = 8'b00011100;
  localparam logic [RI10_W-1:0] OPC_LQD  = 8'b00110100;
  localparam logic [RI10_W-1:0] OPC_STQD = 8'b00100100;
  localparam logic [RI16_W-1:0] OPC_IL   = 9'b010000001;
  localparam logic [RI16_W-1:0] OPC_BR   = 9'b001100100;
  localparam logic [RR_W-1:0]   OPC_A    = 11'b00011000000;
  localparam logic [RR_W-1:0]   OPC_NOP  = 11'b01000000001;
  localparam logic [RR_W-1:0]   OPC_LNOP = 11'b00000000001;
  localparam logic [RR_W-1:0]   OPC_SHLQ = 11'b00111111100;

  localparam int SRC_RA = 3;
  localparam int SRC_RB = 2;
  localparam int SRC_RC = 1;
  localparam int SRC_RT = 0;

  typedef struct packed {
    opcode_t     op;
    pipe_t       pipe;
    logic        writes_rt;
    logic [3:0]  src_mask;
    logic [0:6]  ra;
    logic [0:6]  rb;
    logic [0:6]  rc;
    logic [0:6]  rt;
    logic [0:6]  I7;
    logic [0:9]  I10;
    logic [0:15] I16;
    logic [0:17] I18;
  } decoded_t;

  typedef struct packed {
    opcode_t     op;
    logic [0:6]  ra;
    logic [0:6]  rb;
    logic [0:6]  rc;
    logic [0:6]  rt;
    logic [0:6]  I7;
    logic [0:9]  I10;
    logic [0:15] I16;
    logic [0:17] I18;
  } slot_t;

  function automatic slot_t to_slot(decoded_t d);
    slot_t s;
    s.op  = d.op;
    s.ra  = d.ra;
    s.rb  = d.rb;
    s.rc  = d.rc;
    s.rt  = d.rt;
    s.I7  = d.I7;
    s.I10 = d.I10;
    s.I16 = d.I16;
    s.I18 = d.I18;
    return s;
  endfunction

  function automatic slot_t idle_slot(opcode_t op);
    slot_t s;
    s = '0;
    s.op = op;
    return s;
  endfunction

endpackage

// File: rtl/dual_issue_stage_instr_decode.sv
// Combinational SPU instruction decoder.
module instr_decode
  import dual_issue_stage_pkg::*;
(
  input  logic [0:31] instr,
  output decoded_t    dec
);

  always_comb begin
    dec = '0;
    dec.op = nop;
    dec.pipe = EVEN;
    unique case (1'b1)
      (instr[0:RRR_W-1] == OPC_FMA): begin
        dec.op = fma;
        dec.writes_rt = 1'b1;
        dec.src_mask = 4'b1110;
        dec.rt = instr[4:10];
        dec.rb = instr[11:17];
        dec.ra = instr[18:24];
        dec.rc = instr[25:31];
      end
      (instr[0:RI18_W-1] == OPC_ILA): begin
        dec.op = ila;
        dec.writes_rt = 1'b1;
        dec.I18 = instr[7:24];
        dec.rt = instr[25:31];
      end
      (instr[0:RI10_W-1] == OPC_AI),
      (instr[0:RI10_W-1] == OPC_LQD): begin
        dec.op = (instr[0:RI10_W-1] == OPC_AI) ? ai : lqd;
        dec.pipe = (instr[0:RI10_W-1] == OPC_AI) ? EVEN : ODD;
        dec.writes_rt = 1'b1;
        dec.src_mask = 4'b1000;
        dec.I10 = instr[8:17];
        dec.ra = instr[18:24];
        dec.rt = instr[25:31];
      end
      (instr[0:RI10_W-1] == OPC_STQD): begin
        dec.op = stqd;
        dec.pipe = ODD;
        dec.src_mask = 4'b1001;
        dec.I10 = instr[8:17];
        dec.ra = instr[18:24];
        dec.rt = instr[25:31];
      end
      (instr[0:RI16_W-1] == OPC_IL): begin
        dec.op = il;
        dec.writes_rt = 1'b1;
        dec.I16 = instr[9:24];
        dec.rt = instr[25:31];
      end
      (instr[0:RI16_W-1] == OPC_BR): begin
        dec.op = br;
        dec.pipe = ODD;
        dec.I16 = instr[9:24];
      end
      (instr[0:RR_W-1] == OPC_A): begin
        dec.op = a;
        dec.writes_rt = 1'b1;
        dec.src_mask = 4'b1100;
        dec.rb = instr[11:17];
        dec.ra = instr[18:24];
        dec.rt = instr[25:31];
      end
      (instr[0:RR_W-1] == OPC_SHLQ): begin
        dec.op = shlqbyi;
        dec.pipe = ODD;
        dec.writes_rt = 1'b1;
        dec.src_mask = 4'b1000;
        dec.I7 = instr[11:17];
        dec.ra = instr[18:24];
        dec.rt = instr[25:31];
      end
      (instr[0:RR_W-1] == OPC_LNOP): begin
        dec.op = lnop;
        dec.pipe = ODD;
      end
      (instr[0:RR_W-1] == OPC_NOP): begin
        dec.op = nop;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dual_issue_stage.sv
// Dual-issue decode stage: routes an instruction pair to even/odd
// pipes, splitting the pair over two cycles on any hazard.
module dual_issue_stage
  import dual_issue_stage_pkg::*;
#(
  parameter opcode_t     NOP_EVEN = nop,
  parameter opcode_t     NOP_ODD  = lnop,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [0:63] instr_pair,
  input  logic [0:31] pc_in,
  input  logic        flush,
  output logic        instr_ready,
  output opcode_t     ep_opcode,
  output opcode_t     op_opcode,
  output logic [0:6]  ra_ep_address,
  output logic [0:6]  rb_ep_address,
  output logic [0:6]  rc_ep_address,
  output logic [0:6]  rt_ep_address,
  output logic [0:6]  ra_op_address,
  output logic [0:6]  rb_op_address,
  output logic [0:6]  rt_op_address,
  output logic [0:6]  I7_ep,
  output logic [0:9]  I10_ep,
  output logic [0:15] I16_ep,
  output logic [0:17] I18_ep,
  output logic [0:6]  I7_op,
  output logic [0:9]  I10_op,
  output logic [0:15] I16_op,
  output logic [0:17] I18_op,
  output logic [0:31] PC_output
);

  decoded_t    da, db;
  state_t      state, state_n;
  slot_t       ep_q, op_q, ep_n, op_n;
  slot_t       held;
  logic        held_odd;
  logic [0:31] held_pc, pc_q, pc_n, pc_sel, pc_b;
  logic        raw, waw, hazard, accept;
  logic        unused_rc;

  instr_decode u_dec_a (.instr(instr_pair[0:31]),  .dec(da));
  instr_decode u_dec_b (.instr(instr_pair[32:63]), .dec(db));

  assign pc_b = pc_in + 32'(PC_STEP);

  always_comb begin
    raw = da.writes_rt &&
          ((db.src_mask[SRC_RA] && db.ra == da.rt) ||
           (db.src_mask[SRC_RB] && db.rb == da.rt) ||
           (db.src_mask[SRC_RC] && db.rc == da.rt) ||
           (db.src_mask[SRC_RT] && db.rt == da.rt));
    waw = da.writes_rt && db.writes_rt && da.rt == db.rt;
    hazard = (da.pipe == db.pipe) || raw || waw;
  end

  assign instr_ready = !reset && !flush && state == EMPTY;
  assign accept = instr_valid && instr_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= EMPTY;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush || state == SECOND) state_n = EMPTY;
    else if (accept && hazard)    state_n = SECOND;
  end

  // Program order: A always lands first, B follows a cycle later on a split.
  always_comb begin
    ep_n = idle_slot(NOP_EVEN);
    op_n = idle_slot(NOP_ODD);
    pc_sel = pc_q;
    if (!flush) begin
      if (state == SECOND) begin
        if (held_odd) begin
          op_n = held;
          pc_sel = held_pc;
        end else begin
          ep_n = held;
        end
      end else if (accept) begin
        if (da.pipe == ODD) begin
          op_n = to_slot(da);
          pc_sel = pc_in;
        end else begin
          ep_n = to_slot(da);
        end
        if (!hazard) begin
          if (db.pipe == ODD) begin
            op_n = to_slot(db);
            pc_sel = pc_b;
          end else begin
            ep_n = to_slot(db);
          end
        end
      end
    end
    pc_n = (op_n.op == NOP_ODD) ? pc_q : pc_sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ep_q     <= idle_slot(NOP_EVEN);
      op_q     <= idle_slot(NOP_ODD);
      pc_q     <= '0;
      held     <= idle_slot(NOP_EVEN);
      held_odd <= 1'b0;
      held_pc  <= '0;
    end else begin
      ep_q <= ep_n;
      op_q <= op_n;
      pc_q <= pc_n;
      if (accept && hazard) begin
        held     <= to_slot(db);
        held_odd <= (db.pipe == ODD);
        held_pc  <= pc_b;
      end
    end
  end

  assign ep_opcode     = ep_q.op;
  assign ra_ep_address = ep_q.ra;
  assign rb_ep_address = ep_q.rb;
  assign rc_ep_address = ep_q.rc;
  assign rt_ep_address = ep_q.rt;
  assign I7_ep         = ep_q.I7;
  assign I10_ep        = ep_q.I10;
  assign I16_ep        = ep_q.I16;
  assign I18_ep        = ep_q.I18;
  assign op_opcode     = op_q.op;
  assign ra_op_address = op_q.ra;
  assign rb_op_address = op_q.rb;
  assign rt_op_address = op_q.rt;
  assign I7_op         = op_q.I7;
  assign I10_op        = op_q.I10;
  assign I16_op        = op_q.I16;
  assign I18_op        = op_q.I18;
  assign PC_output     = pc_q;
  assign unused_rc     = ^op_q.rc;

endmodule

// File: tb/tb_dual_issue_stage.sv
// Directed scoreboard bench for dual_issue_stage.
module tb_dual_issue_stage;
  import dual_issue_stage_pkg::*;

  typedef struct packed {
    opcode_t     eop;
    logic [6:0]  era, erb, erc, ert, ei7;
    logic [9:0]  ei10;
    logic [15:0] ei16;
    logic [17:0] ei18;
    opcode_t     oop;
    logic [6:0]  ora, orb, ort, oi7;
    logic [9:0]  oi10;
    logic [15:0] oi16;
    logic [17:0] oi18;
    logic [31:0] pc;
  } out_t;

  logic        clock = 1'b0;
  logic        reset, instr_valid, flush, instr_ready;
  logic [0:63] instr_pair;
  logic [0:31] pc_in, PC_output;
  opcode_t     ep_opcode, op_opcode;
  logic [0:6]  ra_ep_address, rb_ep_address, rc_ep_address, rt_ep_address;
  logic [0:6]  ra_op_address, rb_op_address, rt_op_address;
  logic [0:6]  I7_ep, I7_op;
  logic [0:9]  I10_ep, I10_op;
  logic [0:15] I16_ep, I16_op;
  logic [0:17] I18_ep, I18_op;

  out_t obs;
  out_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  always #5 clock = ~clock;

  dual_issue_stage dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_pair(instr_pair), .pc_in(pc_in), .flush(flush),
    .instr_ready(instr_ready),
    .ep_opcode(ep_opcode), .op_opcode(op_opcode),
    .ra_ep_address(ra_ep_address), .rb_ep_address(rb_ep_address),
    .rc_ep_address(rc_ep_address), .rt_ep_address(rt_ep_address),
    .ra_op_address(ra_op_address), .rb_op_address(rb_op_address),
    .rt_op_address(rt_op_address),
    .I7_ep(I7_ep), .I10_ep(I10_ep), .I16_ep(I16_ep), .I18_ep(I18_ep),
    .I7_op(I7_op), .I10_op(I10_op), .I16_op(I16_op), .I18_op(I18_op),
    .PC_output(PC_output)
  );

  always_comb begin
    obs.eop  = ep_opcode;
    obs.era  = ra_ep_address;
    obs.erb  = rb_ep_address;
    obs.erc  = rc_ep_address;
    obs.ert  = rt_ep_address;
    obs.ei7  = I7_ep;
    obs.ei10 = I10_ep;
    obs.ei16 = I16_ep;
    obs.ei18 = I18_ep;
    obs.oop  = op_opcode;
    obs.ora  = ra_op_address;
    obs.orb  = rb_op_address;
    obs.ort  = rt_op_address;
    obs.oi7  = I7_op;
    obs.oi10 = I10_op;
    obs.oi16 = I16_op;
    obs.oi18 = I18_op;
    obs.pc   = PC_output;
  end

  // Encoders built straight from the SPU instruction formats.
  function automatic logic [31:0] enc_a(logic [6:0] rt, logic [6:0] ra, logic [6:0] rb);
    return {11'b00011000000, rb, ra, rt};
  endfunction
  function automatic logic [31:0] enc_fma(logic [6:0] rt, logic [6:0] ra, logic [6:0] rb, logic [6:0] rc);
    return {4'b1110, rt, rb, ra, rc};
  endfunction
  function automatic logic [31:0] enc_ri10(logic [7:0] op, logic [6:0] rt, logic [9:0] i10, logic [6:0] ra);
    return {op, i10, ra, rt};
  endfunction
  function automatic logic [31:0] enc_ri16(logic [8:0] op, logic [6:0] rt, logic [15:0] i16);
    return {op, i16, rt};
  endfunction
  function automatic logic [31:0] enc_ila(logic [6:0] rt, logic [17:0] i18);
    return {7'b0100001, i18, rt};
  endfunction
  function automatic logic [31:0] enc_shlqbyi(logic [6:0] rt, logic [6:0] ra, logic [6:0] i7);
    return {11'b00111111100, i7, ra, rt};
  endfunction

  function automatic out_t idle(logic [31:0] pc);
    out_t e;
    e = '0;
    e.eop = nop;
    e.oop = lnop;
    e.pc = pc;
    return e;
  endfunction

  function automatic out_t put_e(out_t e0, opcode_t op, logic [6:0] ra, logic [6:0] rb,
                                 logic [6:0] rc, logic [6:0] rt, logic [6:0] i7,
                                 logic [9:0] i10, logic [15:0] i16, logic [17:0] i18);
    out_t e;
    e = e0;
    e.eop = op; e.era = ra; e.erb = rb; e.erc = rc; e.ert = rt;
    e.ei7 = i7; e.ei10 = i10; e.ei16 = i16; e.ei18 = i18;
    return e;
  endfunction

  function automatic out_t put_o(out_t e0, opcode_t op, logic [6:0] ra, logic [6:0] rb,
                                 logic [6:0] rt, logic [6:0] i7, logic [9:0] i10,
                                 logic [15:0] i16, logic [17:0] i18);
    out_t e;
    e = e0;
    e.oop = op; e.ora = ra; e.orb = rb; e.ort = rt;
    e.oi7 = i7; e.oi10 = i10; e.oi16 = i16; e.oi18 = i18;
    return e;
  endfunction

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] pc);
    instr_valid = 1'b1;
    instr_pair = {i0, i1};
    pc_in = pc;
  endtask

  task automatic tick(input logic exp_ready);
    out_t e;
    step_no++;
    #1;
    total++;
    assert (instr_ready === exp_ready)
      else begin
        bad++;
        $error("FAIL ready step=%0d obs=%0b exp=%0b", step_no, instr_ready, exp_ready);
      end
    @(posedge clock);
    #1;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard step=%0d obs=empty exp=entry", step_no);
    end else begin
      e = sb.pop_front();
      assert (obs === e)
        else begin
          bad++;
          $error("FAIL out step=%0d obs=%h exp=%h", step_no, obs, e);
        end
    end
  endtask

  logic [31:0] i_a, i_lqd, i_fma;
  logic [31:0] i_ila, i_br;
  out_t e;

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_pair = '0;
    pc_in = '0;
    flush = 1'b0;
    i_a   = enc_a(3, 1, 2);
    i_lqd = enc_ri10(8'b00110100, 4, 10'h10, 5);
    i_fma = enc_fma(6, 3, 7, 8);
    i_ila = enc_ila(1, 18'h12345);
    i_br  = enc_ri16(9'b001100100, 0, 16'h0040);
    @(posedge clock);
    #1;

    sb.push_back(idle(0)); tick(1'b0);
    reset = 1'b0;
    sb.push_back(idle(0)); tick(1'b1);

    // no hazard: a even, lqd odd
    drive(i_a, i_lqd, 32'h100);
    e = put_e(idle(32'h104), a, 1, 2, 0, 3, 0, 0, 0, 0);
    sb.push_back(put_o(e, lqd, 5, 0, 4, 0, 10'h10, 0, 0)); tick(1'b1);
    instr_valid = 1'b0;
    sb.push_back(idle(32'h104)); tick(1'b1);

    // structural hazard: both even
    drive(i_a, i_fma, 32'h200);
    sb.push_back(put_e(idle(32'h104), a, 1, 2, 0, 3, 0, 0, 0, 0)); tick(1'b1);
    sb.push_back(put_e(idle(32'h104), fma, 3, 7, 8, 6, 0, 0, 0, 0)); tick(1'b0);
    instr_valid = 1'b0;
    sb.push_back(idle(32'h104)); tick(1'b1);

    // RAW through store rt
    drive(enc_ri16(9'b010000001, 9, 16'd5), enc_ri10(8'b00100100, 9, 0, 2), 32'h300);
    sb.push_back(put_e(idle(32'h104), il, 0, 0, 0, 9, 0, 0, 16'd5, 0)); tick(1'b1);
    sb.push_back(put_o(idle(32'h304), stqd, 2, 0, 9, 0, 0, 0, 0)); tick(1'b0);
    instr_valid = 1'b0;
    sb.push_back(idle(32'h304)); tick(1'b1);

    // odd then even, no hazard
    drive(enc_ri10(8'b00110100, 4, 10'h20, 6), enc_a(10, 1, 2), 32'h400);
    e = put_e(idle(32'h400), a, 1, 2, 0, 10, 0, 0, 0, 0);
    sb.push_back(put_o(e, lqd, 6, 0, 4, 0, 10'h20, 0, 0)); tick(1'b1);
    instr_valid = 1'b0;
    sb.push_back(idle(32'h400)); tick(1'b1);

    // WAW across pipes
    drive(enc_ri10(8'b00011100, 5, 10'd3, 1), enc_shlqbyi(5, 2, 7), 32'h500);
    sb.push_back(put_e(idle(32'h400), ai, 1, 0, 0, 5, 0, 10'd3, 0, 0)); tick(1'b1);
    sb.push_back(put_o(idle(32'h504), shlqbyi, 2, 0, 5, 7, 0, 0, 0)); tick(1'b0);
    instr_valid = 1'b0;
    sb.push_back(idle(32'h504)); tick(1'b1);

    // flush while holding B
    drive(i_a, i_fma, 32'h600);
    sb.push_back(put_e(idle(32'h504), a, 1, 2, 0, 3, 0, 0, 0, 0)); tick(1'b1);
    flush = 1'b1;
    drive(i_ila, i_br, 32'h700);
    sb.push_back(idle(32'h504)); tick(1'b0);
    flush = 1'b0;
    instr_valid = 1'b0;
    sb.push_back(idle(32'h504)); tick(1'b1);

    // flush in EMPTY blocks acceptance
    flush = 1'b1;
    drive(i_ila, i_br, 32'h700);
    sb.push_back(idle(32'h504)); tick(1'b0);
    flush = 1'b0;
    instr_valid = 1'b0;
    sb.push_back(idle(32'h504)); tick(1'b1);
    drive(i_ila, i_br, 32'h700);
    e = put_e(idle(32'h704), ila, 0, 0, 0, 1, 0, 0, 0, 18'h12345);
    sb.push_back(put_o(e, br, 0, 0, 0, 0, 0, 16'h0040, 0)); tick(1'b1);

    // unknown encoding decodes to nop
    drive(32'hFFFF_FFFF, i_lqd, 32'h800);
    sb.push_back(put_o(idle(32'h804), lqd, 5, 0, 4, 0, 10'h10, 0, 0)); tick(1'b1);

    // reset while holding B
    drive(i_a, i_fma, 32'h900);
    sb.push_back(put_e(idle(32'h804), a, 1, 2, 0, 3, 0, 0, 0, 0)); tick(1'b1);
    reset = 1'b1;
    sb.push_back(idle(0)); tick(1'b0);
    reset = 1'b0;
    instr_valid = 1'b0;
    sb.push_back(idle(0)); tick(1'b1);
    drive(i_a, i_lqd, 32'hA00);
    e = put_e(idle(32'hA04), a, 1, 2, 0, 3, 0, 0, 0, 0);
    sb.push_back(put_o(e, lqd, 5, 0, 4, 0, 10'h10, 0, 0)); tick(1'b1);
    instr_valid = 1'b0;
    sb.push_back(idle(32'hA04)); tick(1'b1);

    total++;
    assert (sb.size() == 0)
      else begin
        bad++;
        $error("FAIL drain obs=%0d exp=0", sb.size());
      end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
